// File: rtl/spi_edge_sequencer.sv
// spi_edge_sequencer: bit-serial slave port driven by sys_clk-synchronous SCLK edge pulses.
// Frames words under cs_n, assembles rx words from sdi, serializes tx words onto sdo and
// hands words to/from the core through single-cycle valid/ready strobes.
module spi_edge_sequencer #(
  parameter int unsigned       WIDTH     = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0]  TX_FILL   = '1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sclk_rise,
  input  logic             sclk_fall,
  input  logic             cs_n,
  input  logic             sdi,
  output logic             sdo,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_abort,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic             SDO_RST  = MSB_FIRST ? TX_FILL[WIDTH-1] : TX_FILL[0];

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [WIDTH-1:0]   r_tx_shift;
  logic [WIDTH-1:0]   r_rx_shift;
  logic [WIDTH-1:0]   r_rx_data;
  logic               r_sdo;
  logic               r_tx_ready;
  logic               r_tx_underrun;
  logic               r_rx_valid;
  logic               r_frame_abort;
  logic               r_busy;

  logic               w_lead;
  logic               w_trail;
  logic               w_sample_e;
  logic               w_shift_e;
  logic               w_load;
  logic               w_advance;
  logic               w_sample;
  logic               w_end;
  logic [WIDTH-1:0]   w_tx_load_word;
  logic [WIDTH-1:0]   w_tx_adv;
  logic [WIDTH-1:0]   w_tx_nxt;
  logic [WIDTH-1:0]   w_rx_nxt;
  logic               w_sdo_nxt;

  // Map SCLK rise/fall pulses onto sample/shift events for the selected SPI mode
  assign w_lead     = CPOL ? sclk_fall : sclk_rise;
  assign w_trail    = CPOL ? sclk_rise : sclk_fall;
  assign w_sample_e = CPHA ? w_trail : w_lead;
  assign w_shift_e  = CPHA ? w_lead  : w_trail;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: cs_n alone frames the transfer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!cs_n) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (cs_n)  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Control decode: cs_n rise beats any edge, sample beats a coincident shift
  always_comb begin
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_sample  = 1'b0;
    w_end     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!cs_n && (CPHA == 1'b0)) w_load = 1'b1;
      end
      S_ACTIVE: begin
        if (cs_n) begin
          w_end = 1'b1;
        end else if (w_sample_e) begin
          w_sample = 1'b1;
        end else if (w_shift_e) begin
          if (r_bit_cnt == '0) w_load = 1'b1;
          else                 w_advance = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shift register next values
  assign w_tx_load_word = tx_valid ? tx_data : TX_FILL;
  assign w_tx_adv       = MSB_FIRST ? {r_tx_shift[WIDTH-2:0], 1'b0} : {1'b0, r_tx_shift[WIDTH-1:1]};
  assign w_tx_nxt       = w_load ? w_tx_load_word : (w_advance ? w_tx_adv : r_tx_shift);
  assign w_rx_nxt       = MSB_FIRST ? {r_rx_shift[WIDTH-2:0], sdi} : {sdi, r_rx_shift[WIDTH-1:1]};
  assign w_sdo_nxt      = MSB_FIRST ? w_tx_nxt[WIDTH-1] : w_tx_nxt[0];

  // Datapath and registered strobes
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_bit_cnt     <= '0;
      r_tx_shift    <= TX_FILL;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_sdo         <= SDO_RST;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_frame_abort <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_frame_abort <= 1'b0;
      r_tx_shift    <= w_tx_nxt;
      r_sdo         <= w_sdo_nxt;
      r_busy        <= (w_state_nxt == S_ACTIVE);
      if (w_load) begin
        r_tx_ready    <= tx_valid;
        r_tx_underrun <= ~tx_valid;
      end
      if (w_end) begin
        r_bit_cnt     <= '0;
        r_rx_shift    <= '0;
        r_frame_abort <= (r_bit_cnt != '0);
      end else if (w_sample) begin
        if (r_bit_cnt == LAST_BIT) begin
          r_bit_cnt  <= '0;
          r_rx_shift <= '0;
          r_rx_data  <= w_rx_nxt;
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
          r_rx_shift <= w_rx_nxt;
        end
      end
    end
  end

  assign sdo         = r_sdo;
  assign tx_ready    = r_tx_ready;
  assign tx_underrun = r_tx_underrun;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_abort = r_frame_abort;
  assign busy        = r_busy;

endmodule
